// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS link controller: control tokens, clock pattern,
// FSM state encoding and default 640x480@60 timing.
package tmds_pkg;

  // Control tokens indexed by {c1, c0}; bit 0 leaves the serializer first.
  localparam logic [9:0] CTL00   = 10'b1101010100;
  localparam logic [9:0] CTL01   = 10'b0010101011;
  localparam logic [9:0] CTL10   = 10'b0101010100;
  localparam logic [9:0] CTL11   = 10'b1010101011;
  localparam logic [9:0] CLK_PAT = 10'b0000011111;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK  = 2'd0,
    ST_SERDES_RST = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_RUN        = 2'd3
  } link_state_e;

  // Control token carrying c1 (vsync level) and c0 (hsync level).
  function automatic logic [9:0] ctl_tok(input logic c1, input logic c0);
    logic [9:0] t;
    case ({c1, c0})
      2'b00:   t = CTL00;
      2'b01:   t = CTL01;
      2'b10:   t = CTL10;
      default: t = CTL11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters: h/v give the position of the next symbol to be emitted,
// with active-region and sync flags decoded from them.
module video_timing_gen
  import tmds_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_clr,
  input  logic        i_adv,
  output logic [11:0] o_h,
  output logic [10:0] o_v,
  output logic        o_act,
  output logic        o_hs,
  output logic        o_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [11:0] h_q, h_d;
  logic [10:0] v_q, v_d;

  // Clear dominates; otherwise step one pixel, wrapping line then frame.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (i_clr) begin
      h_d = '0;
      v_d = '0;
    end else if (i_adv) begin
      if (h_q == 12'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == 11'(V_TOTAL - 1)) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 12'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign o_h   = h_q;
  assign o_v   = v_q;
  assign o_act = (h_q < 12'(H_ACTIVE)) && (v_q < 11'(V_ACTIVE));
  assign o_hs  = (h_q >= 12'(H_ACTIVE + H_FP)) && (h_q < 12'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vs  = (v_q >= 11'(V_ACTIVE + V_FP)) && (v_q < 11'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/tmds_link_ctrl.sv
// HDMI transmit link sequencer: PLL-lock wait, serializer reset, control-token
// flush, then per-pixel selection of video symbols or sync-carrying tokens.
module tmds_link_ctrl
  import tmds_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int RST_CYCLES   = 16,
  parameter int FLUSH_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_pll_locked,
  input  logic        i_enable,
  input  logic [9:0]  i_sym_ch0,
  input  logic [9:0]  i_sym_ch1,
  input  logic [9:0]  i_sym_ch2,
  input  logic        i_sym_valid,
  output logic        o_sym_ready,
  input  logic        i_clr_err,
  output logic        o_serdes_rst,
  output logic [9:0]  o_pdata_ch0,
  output logic [9:0]  o_pdata_ch1,
  output logic [9:0]  o_pdata_ch2,
  output logic [9:0]  o_pdata_clk,
  output logic [11:0] o_hcount,
  output logic [10:0] o_vcount,
  output logic        o_active,
  output logic        o_link_up,
  output logic        o_underflow
);

  link_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  pd0_q, pd0_d, pd1_q, pd1_d, pd2_q, pd2_d;
  logic [11:0] hc_q, hc_d;
  logic [10:0] vc_q, vc_d;
  logic        act_q, act_d, uf_q, uf_d;

  logic [11:0] t_h;
  logic [10:0] t_v;
  logic        t_act, t_hs, t_vs;
  logic        run, link_ok;
  logic [9:0]  blank_tok, idle_tok;

  assign link_ok   = i_pll_locked & i_enable;
  assign run       = (state_q == ST_RUN);
  assign blank_tok = ctl_tok(t_vs ? VS_POL : ~VS_POL, t_hs ? HS_POL : ~HS_POL);
  assign idle_tok  = ctl_tok(~VS_POL, ~HS_POL);

  // Counters sit at (0,0) outside RUN so the first RUN cycle starts the raster.
  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_clr    (~run),
    .i_adv    (run),
    .o_h      (t_h),
    .o_v      (t_v),
    .o_act    (t_act),
    .o_hs     (t_hs),
    .o_vs     (t_vs)
  );

  // Next state and next registered outputs; data-channel tokens are loaded on
  // the edge entering a state so they are valid for its whole duration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pd0_d   = pd0_q;
    pd1_d   = pd1_q;
    pd2_d   = pd2_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    act_d   = act_q;
    uf_d    = i_clr_err ? 1'b0 : uf_q;
    if (!link_ok) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      pd0_d   = '0;
      pd1_d   = '0;
      pd2_d   = '0;
      hc_d    = '0;
      vc_d    = '0;
      act_d   = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          state_d = ST_SERDES_RST;
          cnt_d   = '0;
          pd0_d   = CTL00;
          pd1_d   = CTL00;
          pd2_d   = CTL00;
        end
        ST_SERDES_RST: begin
          if (cnt_q == 16'(RST_CYCLES - 1)) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
            pd0_d   = idle_tok;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == 16'(FLUSH_CYCLES - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          hc_d  = t_h;
          vc_d  = t_v;
          act_d = t_act;
          if (t_act && i_sym_valid) begin
            pd0_d = i_sym_ch0;
            pd1_d = i_sym_ch1;
            pd2_d = i_sym_ch2;
          end else begin
            pd0_d = blank_tok;
            pd1_d = CTL00;
            pd2_d = CTL00;
            if (t_act) uf_d = 1'b1;
          end
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      pd0_q   <= '0;
      pd1_q   <= '0;
      pd2_q   <= '0;
      hc_q    <= '0;
      vc_q    <= '0;
      act_q   <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pd0_q   <= pd0_d;
      pd1_q   <= pd1_d;
      pd2_q   <= pd2_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      act_q   <= act_d;
      uf_q    <= uf_d;
    end
  end

  assign o_serdes_rst = (state_q == ST_WAIT_LOCK) || (state_q == ST_SERDES_RST);
  assign o_pdata_clk  = (state_q == ST_WAIT_LOCK) ? 10'd0 : CLK_PAT;
  assign o_link_up    = run;
  assign o_sym_ready  = run & t_act;
  assign o_pdata_ch0  = pd0_q;
  assign o_pdata_ch1  = pd1_q;
  assign o_pdata_ch2  = pd2_q;
  assign o_hcount     = hc_q;
  assign o_vcount     = vc_q;
  assign o_active     = act_q;
  assign o_underflow  = uf_q;

endmodule

// File: doc/tmds_link_ctrl.md
Name: tmds_link_ctrl

Overview:
Sequences the three TMDS data serializers and the TMDS clock serializer of the HDMI transmit path. Runs the startup sequence: wait for PLL lock, hold the serializers in reset, then flush control tokens. Then generates video timing and selects, per pixel clock, either upstream TMDS-encoded symbols (active region) or control tokens carrying hsync/vsync (blanking). Its outputs drive the 10-bit parallel inputs and reset of the 10:1 serializer instances.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixel clocks)
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
RST_CYCLES, 16, cycles o_serdes_rst held after lock/enable
FLUSH_CYCLES, 1024, control-token cycles before video starts

Ports:
i_clk  in  1  pixel clock (serializer CLKDIV domain)
i_arst_n  in  1  asynchronous active-low reset
i_pll_locked  in  1  PLL lock, already synchronous to i_clk
i_enable  in  1  link enable
i_sym_ch0  in  10  encoded blue/ch0 symbol
i_sym_ch1  in  10  encoded green/ch1 symbol
i_sym_ch2  in  10  encoded red/ch2 symbol
i_sym_valid  in  1  symbols valid
o_sym_ready  out  1  symbols consumed this cycle when valid
i_clr_err  in  1  clears o_underflow
o_serdes_rst  out  1  reset to all serializers
o_pdata_ch0  out  10  parallel data to ch0 serializer
o_pdata_ch1  out  10  parallel data to ch1 serializer
o_pdata_ch2  out  10  parallel data to ch2 serializer
o_pdata_clk  out  10  parallel data to clock-channel serializer
o_hcount  out  12  x position of symbol on o_pdata_*
o_vcount  out  11  y position of symbol on o_pdata_*
o_active  out  1  symbol on o_pdata_* is active video
o_link_up  out  1  FSM in RUN
o_underflow  out  1  sticky: ready while !valid

Behaviour:
- Reset values: o_serdes_rst=1; all o_pdata_*=0; o_sym_ready=0; o_hcount=0; o_vcount=0; o_active=0; o_link_up=0; o_underflow=0. FSM=WAIT_LOCK.
- Constants (bit0 serialized first): CTL(c1,c0): 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011. CLK_PAT=0000011111.
- FSM:
  - WAIT_LOCK: rst=1, pdata=0. Go to SERDES_RST when i_pll_locked & i_enable.
  - SERDES_RST: rst=1, o_pdata_clk=CLK_PAT, data channels CTL00, for exactly RST_CYCLES cycles.
  - FLUSH: rst=0, FLUSH_CYCLES cycles. ch0=CTL(vs_inactive, hs_inactive); ch1/ch2=CTL00.
  - RUN: link_up=1. Timing counters start at h=0, v=0 on the first RUN cycle.
  - From any state, !i_pll_locked or !i_enable means the next cycle is WAIT_LOCK with reset-value outputs (except o_underflow). Counters clear.
- Timing: internal h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1 give the position of the next emitted symbol. H_TOTAL=sum of H_*; V_TOTAL=sum of V_*. h wraps to 0 and v increments; v wraps at V_TOTAL.
  - act = h<H_ACTIVE && v<V_ACTIVE.
  - hs asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs likewise on v.
  - Sync wire level = asserted ? POL : !POL.
- o_sym_ready = RUN & act, combinational from registers only (no dependence on i_sym_valid).
- Each RUN edge:
  - If act & valid: o_pdata_chN <= i_sym_chN.
  - If act & !valid: ch0=CTL(vs_lvl,hs_lvl), ch1/ch2=CTL00, o_underflow <= 1.
  - If !act: the same control tokens are emitted.
  - o_hcount/o_vcount/o_active <= h/v/act.
  - Latency from handshake to o_pdata is 1 cycle.
- o_pdata_clk = CLK_PAT in every state except WAIT_LOCK.
- o_underflow: set has priority over i_clr_err in the same cycle. The flag is cleared only by i_clr_err or reset.

Decomposition:
- Package tmds_pkg: CTL00..CTL11, CLK_PAT, FSM state enum, 640x480 default timing constants.
- Sub-module video_timing_gen: h/v counters, act/hs/vs generation, synchronous clear input.

Test Plan:
- Startup with defaults, lock=enable=1 after reset:
  - o_serdes_rst stays 1 for exactly 16 cycles after leaving WAIT_LOCK.
  - Then 1024 cycles with ch0=1010101011 and ch1/ch2=1101010100.
  - o_link_up rises on the next cycle.
- Active line, valid tied high, ch0 symbol = counter:
  - 640 handshakes per line; each symbol appears on o_pdata_ch0 one cycle after acceptance with o_hcount equal to its x.
  - Hcount 640..655 gives ch0=1010101011.
  - Hcount 656..751 gives ch0=0101010100.
- Full frame:
  - 420000 cycles between o_hcount=0,o_vcount=0 occurrences.
  - Lines 490..491 give ch0=0010101011 outside hsync.
  - Lines 490..491 with hsync give ch0=CTL00.
- Underflow: valid low for 3 cycles at h=100.
  - 3 blanking tokens emitted, no handshakes.
  - o_underflow=1 and held.
  - A pulse of i_clr_err coinciding with a new underflow leaves it 1.
- Lock loss at h=300:
  - Next cycle: o_serdes_rst=1, o_sym_ready=0, o_link_up=0, all o_pdata=0.
  - On relock, the full 16+1024 sequence repeats and video restarts at (0,0).
- Enable deassert during FLUSH: WAIT_LOCK next cycle; no RUN entry until enable returns.
